// File: rtl/pingpong_index_buffer.sv
// Double-buffered index store: one bank fills from the write path while the other
// is presented as a flat bus; the consumer hands a bank back with index_release.
module pingpong_index_buffer #(
    parameter int DEPTH    = 81,
    parameter int INDEX_W  = 7,
    parameter int DATA_W   = 32,
    parameter int PER_WORD = 1,
    parameter int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       write_enable,
    input  logic                       soft_clear,
    input  logic                       index_release,
    output logic                       write_ready,
    output logic                       index_buffer_ready,
    output logic [DEPTH*INDEX_W-1:0]   index_flat,
    output logic [CNT_W-1:0]           fill_count,
    output logic                       overflow_err
);

    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_S    = SUM_W'(DEPTH);
    localparam logic [SUM_W-1:0] PER_WORD_S = SUM_W'(PER_WORD);

    logic [1:0]         bank_full, bank_full_nxt;
    logic               wr_sel, wr_sel_nxt;
    logic               rd_sel, rd_sel_nxt;
    logic [CNT_W-1:0]   fill_cnt, fill_cnt_nxt;
    logic               overflow_nxt;

    logic [INDEX_W-1:0] mem [2][DEPTH];
    logic [INDEX_W-1:0] lane [PER_WORD];
    logic [DEPTH-1:0]   slot_we;
    logic [INDEX_W-1:0] slot_wdata [DEPTH];

    logic [SUM_W-1:0]   remain, take, fill_end;
    logic               accept, complete, release_ok;

    always_comb begin
        for (int k = 0; k < PER_WORD; k++) begin
            lane[k] = data_in[k*INDEX_W +: INDEX_W];
        end
    end

    generate
        if (PER_WORD * INDEX_W < DATA_W) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^data_in[DATA_W-1:PER_WORD*INDEX_W];
        end
    endgenerate

    assign write_ready        = !bank_full[wr_sel];
    assign index_buffer_ready = bank_full[rd_sel];
    assign fill_count         = fill_cnt;

    assign accept     = write_enable & write_ready & !soft_clear;
    assign release_ok = index_release & index_buffer_ready & !soft_clear;
    assign remain     = DEPTH_S - {1'b0, fill_cnt};
    // A partial final word only consumes as many lanes as slots remain.
    assign take       = (remain < PER_WORD_S) ? remain : PER_WORD_S;
    assign fill_end   = {1'b0, fill_cnt} + take;
    assign complete   = accept && (fill_end == DEPTH_S);

    always_comb begin
        slot_we = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_wdata[i] = '0;
        end
        for (int k = 0; k < PER_WORD; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && (SUM_W'(k) < take) &&
                    ({1'b0, fill_cnt} + SUM_W'(k) == SUM_W'(i))) begin
                    slot_we[i]    = 1'b1;
                    slot_wdata[i] = lane[k];
                end
            end
        end
    end

    always_comb begin
        bank_full_nxt = bank_full;
        wr_sel_nxt    = wr_sel;
        rd_sel_nxt    = rd_sel;
        fill_cnt_nxt  = fill_cnt;
        overflow_nxt  = overflow_err;
        if (soft_clear) begin
            bank_full_nxt = 2'b00;
            wr_sel_nxt    = 1'b0;
            rd_sel_nxt    = 1'b0;
            fill_cnt_nxt  = '0;
            overflow_nxt  = 1'b0;
        end else begin
            if (write_enable && !write_ready) begin
                overflow_nxt = 1'b1;
            end
            if (complete) begin
                bank_full_nxt[wr_sel] = 1'b1;
                wr_sel_nxt            = !wr_sel;
                fill_cnt_nxt          = '0;
            end else if (accept) begin
                fill_cnt_nxt = fill_end[CNT_W-1:0];
            end
            // Ready implies rd_sel != wr_sel whenever a write is accepted, so
            // completion and release never touch the same bank.
            if (release_ok) begin
                bank_full_nxt[rd_sel] = 1'b0;
                rd_sel_nxt            = !rd_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_full    <= 2'b00;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            fill_cnt     <= '0;
            overflow_err <= 1'b0;
        end else begin
            bank_full    <= bank_full_nxt;
            wr_sel       <= wr_sel_nxt;
            rd_sel       <= rd_sel_nxt;
            fill_cnt     <= fill_cnt_nxt;
            overflow_err <= overflow_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot_we[i] && (wr_sel == 1'(b))) begin
                        mem[b][i] <= slot_wdata[i];
                    end
                end
            end
        end
    end

    always_comb begin
        index_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            index_flat[i*INDEX_W +: INDEX_W] = mem[rd_sel][i];
        end
    end

endmodule

// File: tb/tb_pingpong_index_buffer.sv
// Bench for pingpong_index_buffer: default 81x7 instance with a set scoreboard,
// plus a DEPTH=10 / PER_WORD=4 instance for lane packing.
module tb_pingpong_index_buffer;

    localparam int DEPTH = 81;
    localparam int IW    = 7;
    localparam int DW    = 32;
    localparam int FW    = DEPTH * IW;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PD    = 10;
    localparam int PPW   = 4;
    localparam int PFW   = PD * IW;
    localparam int PCW   = $clog2(PD + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic [DW-1:0]  data_in = '0;
    logic           we = 1'b0, sc = 1'b0, rel = 1'b0;
    logic           write_ready, ready, overflow_err;
    logic [FW-1:0]  index_flat;
    logic [CW-1:0]  fill_count;

    logic [DW-1:0]  p_data = '0;
    logic           p_we = 1'b0, p_sc = 1'b0, p_rel = 1'b0;
    logic           p_write_ready, p_ready, p_overflow;
    logic [PFW-1:0] p_flat;
    logic [PCW-1:0] p_fill;

    int checks = 0;
    int failures = 0;

    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] model_set;
    int            model_cnt;

    always #5 clk = ~clk;

    pingpong_index_buffer dut (
        .clk(clk), .reset(reset), .data_in(data_in), .write_enable(we),
        .soft_clear(sc), .index_release(rel), .write_ready(write_ready),
        .index_buffer_ready(ready), .index_flat(index_flat),
        .fill_count(fill_count), .overflow_err(overflow_err)
    );

    pingpong_index_buffer #(.DEPTH(PD), .INDEX_W(IW), .DATA_W(DW), .PER_WORD(PPW)) dut_p (
        .clk(clk), .reset(reset), .data_in(p_data), .write_enable(p_we),
        .soft_clear(p_sc), .index_release(p_rel), .write_ready(p_write_ready),
        .index_buffer_ready(p_ready), .index_flat(p_flat),
        .fill_count(p_fill), .overflow_err(p_overflow)
    );

    task automatic model_clear();
        exp_q.delete();
        model_set = '0;
        model_cnt = 0;
    endtask

    // One write cycle (optionally with release); starts and ends at a negedge.
    task automatic drive(input logic [IW-1:0] val, input logic rel_in);
        int sz;
        sz = exp_q.size();
        data_in = $urandom();
        data_in[IW-1:0] = val;
        we = 1'b1;
        rel = rel_in;
        if (sz < 2) begin
            model_set[model_cnt*IW +: IW] = val;
            model_cnt++;
            if (model_cnt == DEPTH) begin
                exp_q.push_back(model_set);
                model_cnt = 0;
            end
        end
        if (rel_in && sz > 0) void'(exp_q.pop_front());
        @(negedge clk);
        we = 1'b0;
        rel = 1'b0;
    endtask

    task automatic pulse_release();
        int sz;
        sz = exp_q.size();
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        if (sz > 0) void'(exp_q.pop_front());
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        checks++; if (fill_count !== '0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_count); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", ready); end
        checks++; if (write_ready !== 1'b1) begin failures++; $display("FAIL reset_write_ready got=%0b exp=1", write_ready); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow_err); end
        checks++; if (index_flat !== '0) begin failures++; $display("FAIL reset_flat got=%h exp=0", index_flat); end
        checks++; if (p_flat !== '0 || p_ready !== 1'b0) begin failures++; $display("FAIL reset_p got flat=%h ready=%0b exp 0/0", p_flat, p_ready); end
    endtask

    task automatic test_packing();
        logic [PFW-1:0] exp_p;
        exp_p = '0;
        for (int i = 0; i < 8; i++) exp_p[i*IW +: IW] = IW'(i + 1);
        exp_p[8*IW +: IW] = 7'h11;
        exp_p[9*IW +: IW] = 7'h22;
        p_we = 1'b1;
        p_data = {4'hA, 7'd4, 7'd3, 7'd2, 7'd1};
        @(negedge clk);
        checks++; if (p_fill !== PCW'(4)) begin failures++; $display("FAIL pack_fill1 got=%0d exp=4", p_fill); end
        p_data = {4'h5, 7'd8, 7'd7, 7'd6, 7'd5};
        @(negedge clk);
        checks++; if (p_fill !== PCW'(8) || p_ready !== 1'b0) begin failures++; $display("FAIL pack_fill2 got fill=%0d ready=%0b exp 8/0", p_fill, p_ready); end
        p_data = {4'hF, 7'h44, 7'h33, 7'h22, 7'h11};
        @(negedge clk);
        p_we = 1'b0;
        checks++; if (p_fill !== '0) begin failures++; $display("FAIL pack_fill3 got=%0d exp=0", p_fill); end
        checks++; if (p_ready !== 1'b1 || p_write_ready !== 1'b1) begin failures++; $display("FAIL pack_ready got ready=%0b wr=%0b exp 1/1", p_ready, p_write_ready); end
        checks++; if (p_flat[8*IW +: 2*IW] !== {7'h22, 7'h11}) begin failures++; $display("FAIL pack_tail got=%h exp=%h", p_flat[8*IW +: 2*IW], {7'h22, 7'h11}); end
        checks++; if (p_flat !== exp_p) begin failures++; $display("FAIL pack_flat got=%h exp=%h", p_flat, exp_p); end
    endtask

    task automatic test_fill_first();
        for (int i = 0; i < DEPTH; i++) begin
            drive(IW'(i), 1'b0);
            if (i == DEPTH - 2) begin
                checks++; if (ready !== 1'b0 || fill_count !== CW'(DEPTH - 1)) begin failures++; $display("FAIL fill_pre got ready=%0b fill=%0d exp 0/80", ready, fill_count); end
            end
        end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready got=%0b exp=1", ready); end
        checks++; if (index_flat !== exp_q[0]) begin failures++; $display("FAIL fill_flat got=%h exp=%h", index_flat, exp_q[0]); end
        checks++; if (index_flat[80*IW +: IW] !== 7'd80) begin failures++; $display("FAIL fill_slot80 got=%0d exp=80", index_flat[80*IW +: IW]); end
        checks++; if (fill_count !== '0 || write_ready !== 1'b1) begin failures++; $display("FAIL fill_post got fill=%0d wr=%0b exp 0/1", fill_count, write_ready); end
    endtask

    task automatic test_pingpong();
        for (int i = 0; i < DEPTH; i++) drive(IW'(100 - i), 1'b0);
        checks++; if (write_ready !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL pp_full got wr=%0b ready=%0b exp 0/1", write_ready, ready); end
        checks++; if (index_flat !== exp_q[0]) begin failures++; $display("FAIL pp_hold got=%h exp=%h", index_flat, exp_q[0]); end
        pulse_release();
        checks++; if (ready !== 1'b1 || write_ready !== 1'b1) begin failures++; $display("FAIL pp_swap got ready=%0b wr=%0b exp 1/1", ready, write_ready); end
        checks++; if (index_flat[0 +: IW] !== 7'd100 || index_flat[80*IW +: IW] !== 7'd20) begin failures++; $display("FAIL pp_slots got s0=%0d s80=%0d exp 100/20", index_flat[0 +: IW], index_flat[80*IW +: IW]); end
        checks++; if (index_flat !== exp_q[0]) begin failures++; $display("FAIL pp_flat got=%h exp=%h", index_flat, exp_q[0]); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(IW'((i * 3) % 128), 1'b0);
        checks++; if (write_ready !== 1'b0) begin failures++; $display("FAIL ovf_wr got=%0b exp=0", write_ready); end
        drive(7'h7f, 1'b0);
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0b exp=1", overflow_err); end
        checks++; if (fill_count !== '0 || index_flat !== exp_q[0]) begin failures++; $display("FAIL ovf_nochange got fill=%0d flat=%h exp 0/%h", fill_count, index_flat, exp_q[0]); end
        @(negedge clk);
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b exp=1", overflow_err); end
        sc = 1'b1; we = 1'b1; rel = 1'b1;
        @(negedge clk);
        sc = 1'b0; we = 1'b0; rel = 1'b0;
        model_clear();
        checks++; if (overflow_err !== 1'b0 || ready !== 1'b0) begin failures++; $display("FAIL clr_state got ovf=%0b ready=%0b exp 0/0", overflow_err, ready); end
        checks++; if (write_ready !== 1'b1 || fill_count !== '0) begin failures++; $display("FAIL clr_prio got wr=%0b fill=%0d exp 1/0", write_ready, fill_count); end
        pulse_release();
        checks++; if (ready !== 1'b0 || write_ready !== 1'b1) begin failures++; $display("FAIL rel_idle got ready=%0b wr=%0b exp 0/1", ready, write_ready); end
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < DEPTH; i++) drive(IW'(i) ^ 7'h55, 1'b0);
        checks++; if (ready !== 1'b1 || index_flat !== exp_q[0]) begin failures++; $display("FAIL sc_a got ready=%0b flat=%h exp 1/%h", ready, index_flat, exp_q[0]); end
        for (int i = 0; i < DEPTH - 1; i++) drive(~IW'(i), 1'b0);
        checks++; if (fill_count !== CW'(DEPTH - 1) || ready !== 1'b1) begin failures++; $display("FAIL sc_b80 got fill=%0d ready=%0b exp 80/1", fill_count, ready); end
        drive(7'h3c, 1'b1);
        checks++; if (ready !== 1'b1 || write_ready !== 1'b1) begin failures++; $display("FAIL sc_ready got ready=%0b wr=%0b exp 1/1", ready, write_ready); end
        checks++; if (index_flat !== exp_q[0]) begin failures++; $display("FAIL sc_flat got=%h exp=%h", index_flat, exp_q[0]); end
        checks++; if (index_flat[80*IW +: IW] !== 7'h3c || fill_count !== '0) begin failures++; $display("FAIL sc_last got s80=%h fill=%0d exp 3c/0", index_flat[80*IW +: IW], fill_count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 40; i++) drive(IW'(i + 1), 1'b0);
        checks++; if (fill_count !== CW'(40) || ready !== 1'b1) begin failures++; $display("FAIL ar_pre got fill=%0d ready=%0b exp 40/1", fill_count, ready); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (fill_count !== '0 || ready !== 1'b0) begin failures++; $display("FAIL ar_ctrl got fill=%0d ready=%0b exp 0/0", fill_count, ready); end
        checks++; if (index_flat !== '0) begin failures++; $display("FAIL ar_flat got=%h exp=0", index_flat); end
        checks++; if (write_ready !== 1'b1 || overflow_err !== 1'b0) begin failures++; $display("FAIL ar_misc got wr=%0b ovf=%0b exp 1/0", write_ready, overflow_err); end
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_packing();
        test_fill_first();
        test_pingpong();
        test_overflow();
        test_same_cycle();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/pingpong_index_buffer.md
Name: pingpong_index_buffer

Overview:
- Parametrised, double-buffered successor to the single-shot index buffer.
- Collects DEPTH indices of INDEX_W bits from the AXI write path, packing PER_WORD indices per bus word.
- Presents a complete index set as one flat bus to the data preprocessing unit.
- While the consumer works on one bank, the next set fills the other bank. The consumer frees a bank with a release pulse, so reloading needs no reset.

Parameters:
DEPTH, 81, number of indices per set
INDEX_W, 7, bits per index
DATA_W, 32, width of data_in
PER_WORD, 1, indices packed per write word; legal range 1..DATA_W/INDEX_W
CNT_W, $clog2(DEPTH+1), width of fill_count

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
data_in  in  DATA_W  packed indices from the AXI interface; lane k = data_in[k*INDEX_W +: INDEX_W]
write_enable  in  1  write strobe
soft_clear  in  1  synchronous clear of all buffer state
index_release  in  1  consumer has finished with the presented set
write_ready  out  1  high when the fill bank can accept a write
index_buffer_ready  out  1  high when a complete set is presented on index_flat
index_flat  out  DEPTH*INDEX_W  presented set; slot i = index_flat[i*INDEX_W +: INDEX_W]
fill_count  out  CNT_W  number of indices stored so far in the current fill bank
overflow_err  out  1  sticky; a write was attempted while write_ready was 0

Behaviour:
- Storage: two banks, each DEPTH x INDEX_W.
- State registers: bank_full[1:0], wr_sel (bank being filled), rd_sel (bank presented), fill_cnt.
- Reset (reset=0, asynchronous):
  - bank_full=00, wr_sel=0, rd_sel=0, fill_cnt=0, overflow_err=0.
  - All bank storage is zeroed, so index_flat=0 and index_buffer_ready=0.
  - write_ready=1 from the first cycle after reset deassertion.
  - Reset mid-fill or mid-consume discards everything.
- Output decode:
  - write_ready = !bank_full[wr_sel].
  - index_buffer_ready = bank_full[rd_sel].
  - index_flat is driven by bank rd_sel.
  - fill_count = fill_cnt.
- Accepted write: write_enable & write_ready & !soft_clear.
  - Lanes k = 0..n-1 are stored at slots fill_cnt+k of bank wr_sel, where n = min(PER_WORD, DEPTH-fill_cnt).
  - Lanes at or above n are ignored. This covers a partial final word when DEPTH mod PER_WORD != 0.
  - fill_cnt advances by n.
- Bank completion: when an accepted write brings fill_cnt+n to DEPTH:
  - bank_full[wr_sel] is set, wr_sel toggles and fill_cnt returns to 0, all on the same clock edge.
  - index_buffer_ready rises the cycle after that final write if rd_sel points at the completed bank.
  - Once both banks are full, write_ready drops.
- Rejected write: write_enable & !write_ready.
  - Data is dropped and no state changes, except overflow_err is set.
  - overflow_err stays set until reset or soft_clear.
- Release:
  - index_release while index_buffer_ready is high clears bank_full[rd_sel] and toggles rd_sel.
  - If the other bank is already full, index_buffer_ready stays high and index_flat shows the new set on the next cycle with no bubble.
  - index_release while index_buffer_ready is low is ignored.
- Simultaneous final write and release: both updates apply on the same edge and touch different banks (wr_sel != rd_sel whenever ready=1). On the next cycle rd_sel points at the just-completed bank and ready=1.
- soft_clear:
  - Has priority over write and release in the same cycle.
  - Sets bank_full=00, wr_sel=0, rd_sel=0, fill_cnt=0, overflow_err=0.
  - Bank contents are not zeroed.
- Bank contents change only through accepted writes or reset. A presented set is never modified while index_buffer_ready=1.

Test Plan:
- Defaults: reset low 3 cycles, release, write 81 words with data_in[6:0]=i -> after write 81, ready=1 on the next cycle; slot i=i for i=0..80; fill_count=0; write_ready=1.
- Ping-pong: with no release, fill a second set of 81 words with value 100-i -> write_ready=0, presented set unchanged; pulse index_release -> next cycle ready=1 and slot0=100, slot80=20; write_ready=1.
- Overflow: both banks full, write_enable pulsed once -> overflow_err=1 and sticky, fill_count=0, banks unchanged; soft_clear -> overflow_err=0, ready=0, write_ready=1.
- Packing, PER_WORD=4, DEPTH=10: write 3 words, the last carrying lanes 0x11,0x22,0x33,0x44 -> fill_count goes 4, 8, 10->0; slots 8,9 = 0x11,0x22; lanes 0x33,0x44 discarded; ready=1.
- Same-cycle: bank A presented, bank B at 80 indices; apply the 81st write together with index_release -> next cycle ready=1 showing bank B; bank A free and write_ready=1.
- Async reset asserted mid-fill (fill_count=40) between clock edges -> fill_count, ready and index_flat read 0 immediately, without waiting for a clock edge.
